alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Downstream stage of the 3-bit ALU. Samples each ALU result (Y, Cout) with its opcode (sel) on a valid strobe and derives a zero flag. Buffers the tagged results in a small first-word-fall-through FIFO for a slower consumer (output pins or a serial reader). Also keeps carry statistics and a sticky drop flag, because the combinational ALU upstream cannot be stalled.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 8, width of saturating carry counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ALU result present this cycle
in_ready  output  1  FIFO can accept; equals not full
in_y  input  3  ALU result Y
in_cout  input  1  ALU carry/borrow out
in_sel  input  2  ALU opcode that produced the result
out_valid  output  1  head entry valid (FIFO not empty)
out_ready  input  1  consumer accepts head entry
out_data  output  8  head entry {1'b0, sel[1:0], cout, zero, y[2:0]}
count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
carry_cnt  output  CNT_W  number of accepted entries with cout=1, saturating
drop  output  1  sticky: a result arrived while FIFO full
clr_stats  input  1  synchronous clear of carry_cnt and drop

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1, out_data=8'h00, carry_cnt=0, drop=0. Storage contents are don't-care but must never reach out_data while out_valid=0; out_data is forced to 0 when empty.
- Entry formed at push: zero = (in_y==3'b000); entry = {1'b0, in_sel, in_cout, zero, in_y}.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both take effect on the rising clk edge.
- Latency: a push into an empty FIFO gives out_valid=1 and out_data = that entry on the cycle after the push edge. There is no same-cycle bypass.
- FWFT: out_data always shows the entry at rd_ptr. After a pop, the next entry appears the following cycle.
- in_ready = (count != DEPTH). It is registered-state-derived only, with no combinational path from out_ready.
- Full with simultaneous in_valid and out_ready: pop happens, push is refused, drop is set. Full blocks pushes regardless of a pop in the same cycle.
- Empty with simultaneous in_valid and out_ready: push happens, pop does not, since out_valid=0.
- Not full and not empty with push and pop together: count unchanged, both pointers advance.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked explicitly.
- carry_cnt increments on each push with in_cout=1 and holds at 2^CNT_W-1. Refused results are not counted.
- drop is set on in_valid & ~in_ready and holds until clr_stats or rst.
- clr_stats=1: carry_cnt<=0 and drop<=0 on the next edge. clr_stats has priority over an increment/set in the same cycle. FIFO contents are unaffected.
- rst asserted mid-operation: all state clears immediately and in-flight entries are lost. On rst deassertion, first push is accepted on the first clk edge.
- in_valid=0: in_y, in_cout and in_sel are ignored.

Decomposition:
- Shared package alu_pkg:
  - ALU_W=3, SEL_W=2
  - out_data field offsets: Y_LSB=0, ZERO_BIT=3, COUT_BIT=4, SEL_LSB=5
  - alu_entry_t typedef {sel, cout, zero, y}
- One natural sub-module: alu_res_fifo_mem, a DEPTH x 7-bit register array with one write port and asynchronous read at rd_ptr.
- Pointer, count, flag and statistics logic stays in alu_result_fifo.

Test Plan:
- Reset then single push (in_y=3'b101, in_cout=1, in_sel=2'b01), out_ready=0 -> next cycle out_valid=1, out_data=8'h35, count=1, carry_cnt=1.
- Push in_y=0, in_cout=0, in_sel=2'b10 -> out_data=8'h48 (zero flag set); carry_cnt unchanged.
- Fill 4 entries with out_ready=0 -> in_ready=0, count=4. 5th in_valid -> drop=1, count stays 4. Then drain with out_ready=1 for 4 cycles -> entries emerge in push order, out_valid=0 and out_data=0 after the last pop.
- FIFO full with in_valid=1 and out_ready=1 in the same cycle -> count=3 after the edge, drop=1, head advances.
- 300 pushes with in_cout=1 and a continuous pop -> carry_cnt saturates at 255, drop=0, count never exceeds 1. Then clr_stats=1 together with a cout=1 push -> carry_cnt=0.
- Assert rst asynchronously (between edges) with count=3 -> out_valid=0, count=0, in_ready=1 immediately without a clock edge. After release, push then pop -> correct data.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and field layout for the ALU result path.
// The output byte is {1'b0, sel, cout, zero, y}; the stored entry drops the pad bit.
package alu_pkg;

  localparam int ALU_W = 3;
  localparam int SEL_W = 2;
  localparam int OUT_W = 8;

  localparam int Y_LSB    = 0;
  localparam int ZERO_BIT = 3;
  localparam int COUT_BIT = 4;
  localparam int SEL_LSB  = 5;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             cout;
    logic             zero;
    logic [ALU_W-1:0] y;
  } alu_entry_t;

  function automatic alu_entry_t make_entry(
    input logic [ALU_W-1:0] y,
    input logic             cout,
    input logic [SEL_W-1:0] sel
  );
    alu_entry_t e;
    e.sel  = sel;
    e.cout = cout;
    e.zero = (y == '0);
    e.y    = y;
    return e;
  endfunction

  function automatic logic [OUT_W-1:0] pack_out(input alu_entry_t e);
    logic [OUT_W-1:0] d;
    d                       = '0;
    d[Y_LSB +: ALU_W]       = e.y;
    d[ZERO_BIT]             = e.zero;
    d[COUT_BIT]             = e.cout;
    d[SEL_LSB +: SEL_W]     = e.sel;
    return d;
  endfunction

endpackage

// File: rtl/alu_res_fifo_mem.sv
// Entry storage for the result FIFO: one synchronous write port, asynchronous read.
// Contents are not reset; the top masks the read data whenever the FIFO is empty.
module alu_res_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  alu_entry_t       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output alu_entry_t       rd_data
);

  alu_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for tagged ALU results, with a saturating
// carry counter and a sticky drop flag for results the full FIFO had to refuse.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_W-1:0]         in_y,
  input  logic                     in_cout,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic                     drop,
  input  logic                     clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] STAT_MAX = '1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic [CNT_W-1:0] carry_q;
  logic             drop_q;

  logic             push;
  logic             pop;
  alu_entry_t       wr_entry;
  alu_entry_t       rd_entry;

  // Both handshakes depend only on registered occupancy, so out_ready never
  // reaches in_ready combinationally; a full FIFO refuses even when popping.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry  = make_entry(in_y, in_cout, in_sel);

  alu_res_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // clr_stats wins over a same-cycle increment or drop event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= '0;
      drop_q  <= 1'b0;
    end else if (clr_stats) begin
      carry_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (push && in_cout && (carry_q != STAT_MAX)) begin
        carry_q <= carry_q + STAT_ONE;
      end
      if (in_valid && !in_ready) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign out_data  = out_valid ? pack_out(rd_entry) : '0;
  assign count     = count_q;
  assign carry_cnt = carry_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo with a queue scoreboard and a small
// occupancy/statistics model stepped once per clock.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_y;
  logic       in_cout;
  logic [1:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic [7:0] carry_cnt;
  logic       drop;
  logic       clr_stats;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb [$];
  int         m_carry;
  logic       m_drop;
  int         max_count;

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_cout   (in_cout),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .carry_cnt (carry_cnt),
    .drop      (drop),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_entry(input logic [2:0] y, input logic c, input logic [1:0] s);
    return {1'b0, s, c, (y == 3'd0), y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (sb.size() != 0) ? sb[0] : 8'h00;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(sb.size() != DEPTH));
    chk({tag, ".count"},     32'(count),     32'(sb.size()));
    chk({tag, ".out_data"},  32'(out_data),  32'(head));
    chk({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(m_carry));
    chk({tag, ".drop"},      32'(drop),      32'(m_drop));
  endtask

  // One clock: check current outputs, drive inputs, update model, advance to next negedge.
  task automatic cycle(input string tag, input logic v, input logic [2:0] y, input logic c,
                       input logic [1:0] s, input logic ordy, input logic clr);
    logic       full_m, push_m, pop_m;
    logic [7:0] popped;
    check_state(tag);
    in_valid  = v;
    in_y      = y;
    in_cout   = c;
    in_sel    = s;
    out_ready = ordy;
    clr_stats = clr;
    full_m = (sb.size() == DEPTH);
    push_m = v && !full_m;
    pop_m  = ordy && (sb.size() != 0);
    if (pop_m) begin
      popped = sb.pop_front();
      chk({tag, ".pop_data"}, 32'(out_data), 32'(popped));
    end
    if (push_m) sb.push_back(exp_entry(y, c, s));
    if (clr) begin
      m_carry = 0;
      m_drop  = 1'b0;
    end else begin
      if (push_m && c && m_carry < 255) m_carry++;
      if (v && full_m) m_drop = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  task automatic idle(input string tag, input logic ordy);
    cycle(tag, 1'b0, 3'd7, 1'b1, 2'd3, ordy, 1'b0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_carry = 0;
    m_drop  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_y = '0; in_cout = 1'b0; in_sel = '0;
    out_ready = 1'b0; clr_stats = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single push, then zero-flag entry behind it.
    cycle("push1", 1'b1, 3'b101, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("first_entry", 32'(out_data), 32'h35);
    chk("first_carry", 32'(carry_cnt), 32'd1);
    cycle("push_zero", 1'b1, 3'b000, 1'b0, 2'b10, 1'b0, 1'b0);
    idle("pop1", 1'b1);
    chk("zero_entry", 32'(out_data), 32'h48);
    chk("zero_carry", 32'(carry_cnt), 32'd1);
    idle("pop2", 1'b1);
    chk("empty_data", 32'(out_data), 32'h00);

    // Fill, overflow attempt, drain in order.
    cycle("fill0", 1'b1, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 3'd2, 1'b1, 2'd1, 1'b0, 1'b0);
    cycle("fill2", 1'b1, 3'd3, 1'b0, 2'd2, 1'b0, 1'b0);
    cycle("fill3", 1'b1, 3'd4, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    cycle("overflow", 1'b1, 3'd6, 1'b1, 2'd1, 1'b0, 1'b0);
    chk("overflow_drop", 32'(drop), 32'd1);
    chk("overflow_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) idle("drain", 1'b1);
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_data", 32'(out_data), 32'h00);

    // Full with simultaneous push attempt and pop.
    cycle("clr", 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle("refill", 1'b1, 3'(i + 4), 1'(i), 2'(i), 1'b0, 1'b0);
    cycle("full_pushpop", 1'b1, 3'd7, 1'b1, 2'd2, 1'b1, 1'b0);
    chk("fpp_count", 32'(count), 32'd3);
    chk("fpp_drop", 32'(drop), 32'd1);
    chk("fpp_head", 32'(out_data), 32'(exp_entry(3'd5, 1'b1, 2'd1)));
    cycle("mid_pushpop", 1'b1, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0);
    while (sb.size() != 0) idle("drain2", 1'b1);

    // Empty with push and pop together, then saturation under continuous flow.
    cycle("clr2", 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    max_count = 0;
    for (int i = 0; i < 300; i++)
      cycle("sat", 1'b1, 3'(i), 1'b1, 2'(i), 1'b1, 1'b0);
    chk("sat_carry", 32'(carry_cnt), 32'd255);
    chk("sat_drop", 32'(drop), 32'd0);
    chk("sat_maxcount", 32'(max_count), 32'd1);
    cycle("clr_vs_inc", 1'b1, 3'd1, 1'b1, 2'd0, 1'b1, 1'b1);
    chk("clr_carry", 32'(carry_cnt), 32'd0);
    while (sb.size() != 0) idle("drain3", 1'b1);

    // Asynchronous reset with three entries in flight.
    for (int i = 0; i < 3; i++)
      cycle("pre_rst", 1'b1, 3'(i + 1), 1'b1, 2'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_carry", 32'(carry_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst_push", 1'b1, 3'b110, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h66);
    idle("post_rst_pop", 1'b1);
    idle("final", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
